// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4-channel mux scan sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mux_scan_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Handshake, select and result bundle between the scan sequencer and its user/mux.
// Latency: n/a (wiring only).
// Backpressure: none; start is a level request sampled by the sequencer.
interface mux_scan_ctrl_if;
    import mux_scan_pkg::*;

    logic             start;
    logic             continuous;
    logic             mux_out;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic             done;
    logic [NCH-1:0]   sample;
    logic             valid;

    // Sequencer side
    modport master (
        input  start, continuous, mux_out,
        output sel, busy, done, sample, valid
    );

    // Requester / mux side
    modport slave (
        output start, continuous, mux_out,
        input  sel, busy, done, sample, valid
    );
endinterface

// File: rtl/scan_dwell_cnt.sv
// Per-channel dwell counter: clears on load, counts while enabled, flags cnt == SETTLE-1.
// Latency: terminal flag is combinational from the registered count.
// Backpressure: none; load takes priority over enable.
module scan_dwell_cnt
    import mux_scan_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_tc
);

    logic [CNT_W-1:0] r_cnt;

    // Count register: restart at zero on channel entry, advance while settling
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tc = (r_cnt == CNT_W'(SETTLE - 1));

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans a 4:1 mux through channels 0..3, dwelling SETTLE cycles each, and captures a 4-bit word.
// Latency: done/sample appear 4*(SETTLE+1) edges after start is accepted.
// Backpressure: none; start is ignored while busy, continuous chains scans with no idle gap.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic           clk,
    input  logic           rst,
    mux_scan_ctrl_if.master bus
);

    if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
        $error("mux_scan_ctrl: SETTLE must be in 1..255");
    end

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NCH - 1);

    state_e           r_state;
    state_e           w_next;
    logic             w_load;
    logic             w_en;
    logic             w_cap;
    logic             w_tc;
    logic [SEL_W-1:0] r_sel;
    logic [NCH-1:0]   r_shadow;
    logic [NCH-1:0]   w_shadow_nx;
    logic [NCH-1:0]   r_sample;
    logic             r_busy;
    logic             r_done;
    logic             r_valid;

    scan_dwell_cnt #(.SETTLE(SETTLE)) u_dwell (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_en   (w_en),
        .o_tc   (w_tc)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus counter/capture strobes
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_en   = 1'b0;
        w_cap  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = S_SETTLE;
                    w_load = 1'b1;
                end
            end
            S_SETTLE: begin
                w_en = 1'b1;
                if (w_tc) begin
                    w_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_cap = 1'b1;
                if (r_sel == LAST_SEL) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_SETTLE;
                    w_load = 1'b1;
                end
            end
            S_DONE: begin
                if (bus.start || bus.continuous) begin
                    w_next = S_SETTLE;
                    w_load = 1'b1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Shadow word with the current channel's capture merged in
    always_comb begin
        w_shadow_nx        = r_shadow;
        w_shadow_nx[r_sel] = bus.mux_out;
    end

    // Select: step forward after each capture, restart at 0 for a new scan or on return to idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel <= '0;
        end else if (w_load) begin
            r_sel <= (r_state == S_CAPTURE) ? r_sel + SEL_W'(1) : '0;
        end else if (r_state == S_DONE) begin
            r_sel <= '0;
        end
    end

    // Capture path: shadow per channel, sample updated in one shot on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= '0;
            r_sample <= '0;
        end else if (w_cap) begin
            r_shadow <= w_shadow_nx;
            if (r_sel == LAST_SEL) begin
                r_sample <= w_shadow_nx;
            end
        end
    end

    // Registered status flags derived from the upcoming state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_busy  <= (w_next == S_SETTLE) || (w_next == S_CAPTURE);
            r_done  <= (w_next == S_DONE);
            r_valid <= r_valid | (w_next == S_DONE);
        end
    end

    assign bus.sel    = r_sel;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.sample = r_sample;
    assign bus.valid  = r_valid;

endmodule
